// File: rtl/ic0_bus_master_if.sv
// ic0 bus master port bundle: processor-side request/response and ic0 bus side.
interface ic0_bus_master_if #(
   parameter int N_SLV = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wr;
   logic [31:0]           req_addr;
   logic [31:0]           req_data;
   logic                  rsp_valid;
   logic [31:0]           rsp_data;
   logic                  rsp_err;
   logic                  ic0_c_axi_mst_wr_valid;
   logic                  ic0_c_axi_mst_rd_valid;
   logic [31:0]           ic0_axi_mst_wr_addr;
   logic [31:0]           ic0_axi_mst_wr_data;
   logic [31:0]           ic0_axi_mst_rd_addr;
   logic [N_SLV-1:0]      ic0_c_axi_slv_rd_ready;
   logic [32*N_SLV-1:0]   ic0_axi_slv_rd_data;

   modport master (
      input  req_valid, req_wr, req_addr, req_data,
      input  ic0_c_axi_slv_rd_ready, ic0_axi_slv_rd_data,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
      output ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_data,
      output ic0_c_axi_slv_rd_ready, ic0_axi_slv_rd_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
      input  ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr
   );
endinterface

// File: rtl/ic0_bus_master.sv
// ic0 bus master: buffers processor requests in a FIFO and issues them one at
// a time on the ic0 register bus; reads wait for a slave rd_ready with timeout.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a FIFO entry; pops the head and launches it
// S_WR   | write strobe on the bus (posted, no response)
// S_RD   | read strobe on the bus; wait counter cleared
// S_WAIT | waiting for any rd_ready, or timeout after TIMEOUT cycles
// S_RESP | response pulse to the requester
module ic0_bus_master #(
   parameter int N_SLV      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rst,
   ic0_bus_master_if.master  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C    = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0]  TMO_LAST_C = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_RESP} state_t;

   logic              fifo_wr_q   [FIFO_DEPTH];
   logic [31:0]       fifo_addr_q [FIFO_DEPTH];
   logic [31:0]       fifo_data_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic              push, pop;

   state_t            state_q;
   logic [7:0]        wait_cnt_q;
   logic              wr_valid_q, rd_valid_q, rsp_valid_q, rsp_err_q;
   logic [31:0]       wr_addr_q, wr_data_q, rd_addr_q, rsp_data_q;
   logic [31:0]       rd_or;
   logic              rd_multi;

   assign bus.req_ready = (count_q != DEPTH_C);
   assign push = bus.req_valid & bus.req_ready;
   assign pop  = (state_q == S_IDLE) && (count_q != '0);

   // Merge slave return paths; idle slaves drive zero so a plain OR suffices.
   always_comb begin
      rd_or = '0;
      for (int i = 0; i < N_SLV; i++) rd_or = rd_or | bus.ic0_axi_slv_rd_data[32*i +: 32];
      rd_multi = (bus.ic0_c_axi_slv_rd_ready & (bus.ic0_c_axi_slv_rd_ready - N_SLV'(1))) != '0;
   end

   // FIFO storage; contents need no reset since count_q gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wr_q[wr_ptr_q]   <= bus.req_wr;
         fifo_addr_q[wr_ptr_q] <= bus.req_addr;
         fifo_data_q[wr_ptr_q] <= bus.req_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      end
   end

   // Transaction FSM with registered bus strobes and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         wr_valid_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         wr_valid_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (count_q != '0) begin
                  if (fifo_wr_q[rd_ptr_q]) begin
                     state_q    <= S_WR;
                     wr_valid_q <= 1'b1;
                     wr_addr_q  <= fifo_addr_q[rd_ptr_q];
                     wr_data_q  <= fifo_data_q[rd_ptr_q];
                  end else begin
                     state_q    <= S_RD;
                     rd_valid_q <= 1'b1;
                     rd_addr_q  <= fifo_addr_q[rd_ptr_q];
                  end
               end
            end
            S_WR: state_q <= S_IDLE;
            S_RD: begin
               wait_cnt_q <= '0;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.ic0_c_axi_slv_rd_ready != '0) begin
                  rsp_data_q  <= rd_or;
                  rsp_err_q   <= rd_multi;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else if (wait_cnt_q == TMO_LAST_C) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ic0_c_axi_mst_wr_valid = wr_valid_q;
   assign bus.ic0_c_axi_mst_rd_valid = rd_valid_q;
   assign bus.ic0_axi_mst_wr_addr    = wr_addr_q;
   assign bus.ic0_axi_mst_wr_data    = wr_data_q;
   assign bus.ic0_axi_mst_rd_addr    = rd_addr_q;
   assign bus.rsp_valid              = rsp_valid_q;
   assign bus.rsp_data               = rsp_data_q;
   assign bus.rsp_err                = rsp_err_q;
endmodule

// File: tb/tb_ic0_bus_master.sv
// Testbench for ic0_bus_master: directed scenarios plus a randomized stream
// checked against a transaction-level reference model.
module tb_ic0_bus_master;
   localparam int N_SLV = 4, FIFO_DEPTH = 4, TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ic0_bus_master_if #(.N_SLV(N_SLV)) bus ();
   ic0_bus_master #(.N_SLV(N_SLV), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0, n_bad = 0, cyc = 0, viol = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int lat; logic [N_SLV-1:0] mask; logic [32*N_SLV-1:0] d; } plan_t;
   typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; logic err; } ev_t;
   plan_t plan_q[$];
   ev_t   wr_q[$], rd_q[$], rsp_q[$];

   // Reference: what the requester should see for a read given the slave plan.
   function automatic logic [31:0] exp_data(plan_t p);
      logic [31:0] r = '0;
      if (p.lat > TIMEOUT) return '0;
      for (int i = 0; i < N_SLV; i++) if (p.mask[i]) r |= p.d[32*i +: 32];
      return r;
   endfunction
   function automatic logic exp_err(plan_t p);
      if (p.lat > TIMEOUT) return 1'b1;
      return $countones(p.mask) > 1;
   endfunction

   // Bus monitor and slave responder, both on the falling edge.
   logic  prev_strobe = 1'b0;
   int    s_pend = 0, s_wait = 0;
   plan_t s_cur;
   always @(negedge clk) begin
      ev_t e;
      if (bus.ic0_c_axi_mst_wr_valid && bus.ic0_c_axi_mst_rd_valid) viol++;
      if ((bus.ic0_c_axi_mst_wr_valid || bus.ic0_c_axi_mst_rd_valid) && prev_strobe) viol++;
      prev_strobe = bus.ic0_c_axi_mst_wr_valid || bus.ic0_c_axi_mst_rd_valid;
      e.cyc = cyc; e.err = 1'b0;
      if (bus.ic0_c_axi_mst_wr_valid) begin
         e.addr = bus.ic0_axi_mst_wr_addr; e.data = bus.ic0_axi_mst_wr_data; wr_q.push_back(e);
      end
      if (bus.ic0_c_axi_mst_rd_valid) begin
         e.addr = bus.ic0_axi_mst_rd_addr; e.data = '0; rd_q.push_back(e);
      end
      if (bus.rsp_valid) begin
         e.addr = '0; e.data = bus.rsp_data; e.err = bus.rsp_err; rsp_q.push_back(e);
      end
      bus.ic0_c_axi_slv_rd_ready = '0;
      bus.ic0_axi_slv_rd_data    = '0;
      if (s_pend != 0) begin
         if (s_wait <= 1) begin
            bus.ic0_c_axi_slv_rd_ready = s_cur.mask;
            for (int i = 0; i < N_SLV; i++)
               bus.ic0_axi_slv_rd_data[32*i +: 32] = s_cur.mask[i] ? s_cur.d[32*i +: 32] : 32'h0;
            s_pend = 0;
         end else s_wait--;
      end
      if (bus.ic0_c_axi_mst_rd_valid) begin
         if (plan_q.size() > 0) s_cur = plan_q.pop_front();
         else begin s_cur.lat = TIMEOUT + 1; s_cur.mask = '0; s_cur.d = '0; end
         s_pend = 1; s_wait = s_cur.lat;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      wr_q.delete(); rd_q.delete(); rsp_q.delete(); viol = 0;
   endtask

   // Offer one request; acc = edge count at acceptance, stalls = cycles waited.
   task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int acc, output int stalls);
      logic rdy;
      int guard = 0;
      bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = a; bus.req_data = d;
      acc = -1; stalls = 0;
      while (acc < 0 && guard < 200) begin
         rdy = bus.req_ready;
         @(negedge clk);
         if (rdy) acc = cyc; else stalls++;
         guard++;
      end
      bus.req_valid = 1'b0;
      if (acc < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL push_accept got=never exp=accepted within 200 cycles");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      n_cmp++; if (bus.ic0_c_axi_mst_wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_valid got=%b exp=0", bus.ic0_c_axi_mst_wr_valid); end
      n_cmp++; if (bus.ic0_c_axi_mst_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.ic0_c_axi_mst_rd_valid); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp got=%h/%b exp=0/0", bus.rsp_data, bus.rsp_err); end
      n_cmp++; if (bus.ic0_axi_mst_wr_addr !== 32'h0 || bus.ic0_axi_mst_rd_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h/%h exp=0/0", bus.ic0_axi_mst_wr_addr, bus.ic0_axi_mst_rd_addr); end
   endtask

   task automatic test_write();
      int acc, st;
      clear_q();
      push(1'b1, 32'h0000_0454, 32'h5, acc, st);
      idle(6);
      n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL write_count got=%0d exp=1", wr_q.size()); end
      if (wr_q.size() >= 1) begin
         n_cmp++; if (wr_q[0].addr !== 32'h454 || wr_q[0].data !== 32'h5) begin n_bad++; $display("FAIL write_payload got=%h/%h exp=454/5", wr_q[0].addr, wr_q[0].data); end
         n_cmp++; if (wr_q[0].cyc != acc + 1) begin n_bad++; $display("FAIL write_latency got=%0d exp=%0d", wr_q[0].cyc, acc + 1); end
      end
      n_cmp++; if (rsp_q.size() != 0 || rd_q.size() != 0) begin n_bad++; $display("FAIL write_no_rsp got=%0d/%0d exp=0/0", rsp_q.size(), rd_q.size()); end
      n_cmp++; if (bus.ic0_axi_mst_wr_addr !== 32'h454 || bus.ic0_axi_mst_wr_data !== 32'h5) begin n_bad++; $display("FAIL write_hold got=%h/%h exp=454/5", bus.ic0_axi_mst_wr_addr, bus.ic0_axi_mst_wr_data); end
   endtask

   task automatic test_read();
      int acc, st;
      plan_t p;
      clear_q();
      p.lat = 1; p.mask = 4'b0010; p.d = '0; p.d[63:32] = 32'hA;
      plan_q.push_back(p);
      push(1'b0, 32'h0000_0460, 32'h0, acc, st);
      idle(8);
      n_cmp++; if (rd_q.size() != 1) begin n_bad++; $display("FAIL read_strobes got=%0d exp=1", rd_q.size()); end
      if (rd_q.size() >= 1) begin
         n_cmp++; if (rd_q[0].addr !== 32'h460 || rd_q[0].cyc != acc + 1) begin n_bad++; $display("FAIL read_issue got=%h@%0d exp=460@%0d", rd_q[0].addr, rd_q[0].cyc, acc + 1); end
      end
      n_cmp++; if (rsp_q.size() != 1) begin n_bad++; $display("FAIL read_rsp_count got=%0d exp=1", rsp_q.size()); end
      if (rsp_q.size() >= 1) begin
         n_cmp++; if (rsp_q[0].data !== 32'hA || rsp_q[0].err !== 1'b0) begin n_bad++; $display("FAIL read_rsp got=%h/%b exp=a/0", rsp_q[0].data, rsp_q[0].err); end
         n_cmp++; if (rsp_q[0].cyc != acc + 3) begin n_bad++; $display("FAIL read_latency got=%0d exp=%0d", rsp_q[0].cyc, acc + 3); end
      end
   endtask

   // lat = TIMEOUT+1 times out (late ready ignored); lat = TIMEOUT still succeeds.
   task automatic test_timeout();
      int acc, st;
      plan_t p;
      for (int k = 0; k < 2; k++) begin
         clear_q();
         p.lat = (k == 0) ? TIMEOUT + 1 : TIMEOUT;
         p.mask = (k == 0) ? 4'b0001 : 4'b0100;
         p.d = {$urandom, $urandom, $urandom | 32'h1, $urandom | 32'h1};
         plan_q.push_back(p);
         push(1'b0, 32'h0000_0500 + 32'(4*k), 32'h0, acc, st);
         idle(TIMEOUT + 12);
         n_cmp++; if (rsp_q.size() != 1) begin n_bad++; $display("FAIL timeout%0d_rsp_count got=%0d exp=1", k, rsp_q.size()); end
         if (rsp_q.size() >= 1) begin
            n_cmp++; if (rsp_q[0].data !== exp_data(p) || rsp_q[0].err !== exp_err(p)) begin n_bad++; $display("FAIL timeout%0d_rsp got=%h/%b exp=%h/%b", k, rsp_q[0].data, rsp_q[0].err, exp_data(p), exp_err(p)); end
            n_cmp++; if (rsp_q[0].cyc != acc + 2 + TIMEOUT) begin n_bad++; $display("FAIL timeout%0d_latency got=%0d exp=%0d", k, rsp_q[0].cyc, acc + 2 + TIMEOUT); end
         end
         n_cmp++; if (bus.rsp_data !== exp_data(p) || bus.rsp_err !== exp_err(p)) begin n_bad++; $display("FAIL timeout%0d_hold got=%h/%b exp=%h/%b", k, bus.rsp_data, bus.rsp_err, exp_data(p), exp_err(p)); end
      end
   endtask

   task automatic test_multi();
      int acc, st;
      plan_t p;
      clear_q();
      p.lat = $urandom_range(1, 4); p.mask = 4'b0101; p.d = '0;
      p.d[31:0] = 32'h1; p.d[95:64] = 32'h4;
      plan_q.push_back(p);
      push(1'b0, 32'h0000_0600, 32'h0, acc, st);
      idle(10);
      n_cmp++; if (rsp_q.size() != 1) begin n_bad++; $display("FAIL multi_rsp_count got=%0d exp=1", rsp_q.size()); end
      if (rsp_q.size() >= 1) begin
         n_cmp++; if (rsp_q[0].data !== 32'h5 || rsp_q[0].err !== 1'b1) begin n_bad++; $display("FAIL multi_rsp got=%h/%b exp=5/1", rsp_q[0].data, rsp_q[0].err); end
      end
   endtask

   // A stalled read lets 5 queued writes fill the FIFO; the 5th must wait.
   task automatic test_back_to_back();
      int acc, st, st5;
      plan_t p;
      logic [31:0] wd [5];
      clear_q();
      p.lat = TIMEOUT + 1; p.mask = 4'b0001; p.d = '0;
      plan_q.push_back(p);
      push(1'b0, 32'h0000_0700, 32'h0, acc, st);
      st5 = 0;
      for (int i = 0; i < 5; i++) begin
         wd[i] = $urandom;
         push(1'b1, 32'h0000_0800 + 32'(4*i), wd[i], acc, st);
         if (i == 4) st5 = st;
      end
      idle(TIMEOUT + 20);
      n_cmp++; if (st5 == 0) begin n_bad++; $display("FAIL b2b_full_stall got=%0d exp=>0", st5); end
      n_cmp++; if (wr_q.size() != 5) begin n_bad++; $display("FAIL b2b_count got=%0d exp=5", wr_q.size()); end
      for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
         n_cmp++; if (wr_q[i].addr !== 32'h800 + 32'(4*i) || wr_q[i].data !== wd[i]) begin n_bad++; $display("FAIL b2b_order%0d got=%h/%h exp=%h/%h", i, wr_q[i].addr, wr_q[i].data, 32'h800 + 32'(4*i), wd[i]); end
         if (i > 0) begin
            n_cmp++; if (wr_q[i].cyc - wr_q[i-1].cyc != 2) begin n_bad++; $display("FAIL b2b_spacing%0d got=%0d exp=2", i, wr_q[i].cyc - wr_q[i-1].cyc); end
         end
      end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL b2b_strobe_rules got=%0d exp=0", viol); end
   endtask

   task automatic test_reset_wait();
      int acc, st;
      plan_t p;
      clear_q();
      p.lat = 6; p.mask = 4'b0001; p.d = 128'h1234;
      plan_q.push_back(p);
      push(1'b0, 32'h0000_0900, 32'h0, acc, st);
      push(1'b1, 32'h0000_0904, 32'h11, acc, st);
      push(1'b1, 32'h0000_0908, 32'h22, acc, st);
      idle(1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(12);
      n_cmp++; if (rd_q.size() != 1) begin n_bad++; $display("FAIL rstwait_rd got=%0d exp=1", rd_q.size()); end
      n_cmp++; if (rsp_q.size() != 0) begin n_bad++; $display("FAIL rstwait_rsp got=%0d exp=0", rsp_q.size()); end
      n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL rstwait_wr got=%0d exp=0", wr_q.size()); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstwait_ready got=%b exp=1", bus.req_ready); end
      n_cmp++; if (bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rstwait_rsp_regs got=%h/%b exp=0/0", bus.rsp_data, bus.rsp_err); end
   endtask

   task automatic test_random();
      int acc, st;
      plan_t p;
      ev_t e, exp_wr[$], exp_rd[$], exp_rsp[$];
      logic wr;
      clear_q();
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom);
         e.cyc = 0; e.err = 1'b0;
         e.addr = $urandom & 32'hFFFF_FFFC; e.data = $urandom;
         if (wr) exp_wr.push_back(e);
         else begin
            p.lat = $urandom_range(1, TIMEOUT + 1);
            p.mask = N_SLV'($urandom_range(1, (1 << N_SLV) - 1));
            p.d = {$urandom, $urandom, $urandom, $urandom};
            plan_q.push_back(p);
            exp_rd.push_back(e);
            e.data = exp_data(p); e.err = exp_err(p);
            exp_rsp.push_back(e);
         end
         push(wr, e.addr, wr ? e.data : $urandom, acc, st);
         idle($urandom_range(0, 3));
      end
      idle(60);
      n_cmp++; if (wr_q.size() != exp_wr.size() || rd_q.size() != exp_rd.size() || rsp_q.size() != exp_rsp.size()) begin
         n_bad++; $display("FAIL rand_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", wr_q.size(), rd_q.size(), rsp_q.size(), exp_wr.size(), exp_rd.size(), exp_rsp.size());
      end
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
         n_cmp++; if (wr_q[i].addr !== exp_wr[i].addr || wr_q[i].data !== exp_wr[i].data) begin n_bad++; $display("FAIL rand_wr%0d got=%h/%h exp=%h/%h", i, wr_q[i].addr, wr_q[i].data, exp_wr[i].addr, exp_wr[i].data); end
      end
      for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) begin
         n_cmp++; if (rd_q[i].addr !== exp_rd[i].addr) begin n_bad++; $display("FAIL rand_rd%0d got=%h exp=%h", i, rd_q[i].addr, exp_rd[i].addr); end
      end
      for (int i = 0; i < exp_rsp.size() && i < rsp_q.size(); i++) begin
         n_cmp++; if (rsp_q[i].data !== exp_rsp[i].data || rsp_q[i].err !== exp_rsp[i].err) begin n_bad++; $display("FAIL rand_rsp%0d got=%h/%b exp=%h/%b", i, rsp_q[i].data, rsp_q[i].err, exp_rsp[i].data, exp_rsp[i].err); end
      end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rand_strobe_rules got=%0d exp=0", viol); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_data = '0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_multi();
      test_back_to_back();
      test_reset_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
